// File: rtl/adder_share_sched.sv
// adder_share_sched
// Round-robin scheduler that lets NREQ requesters share one external 32-bit
// adder. A request (A, B, add/sub) is accepted in IDLE, its operands are
// presented to the adder for one EXEC cycle, and the captured sum and flags
// are returned to the granted requester in RESP until it accepts them.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   req_valid/req_ready    per-requester request handshake (ready one-hot or 0)
//   req_a, req_b           flattened operands, requester k at [32k+31:32k]
//   req_sub                per-requester 1 = A-B, 0 = A+B
//   rsp_valid/rsp_ready    per-requester response handshake (valid one-hot or 0)
//   rsp_z/rsp_cout/rsp_ovf shared result bus, qualified by rsp_valid
//   busy                   high whenever the FSM is not in IDLE
//   add_a/add_b/add_cin    operands to the shared adder (b pre-inverted for sub)
//   add_z/add_cout         sum and carry from the shared adder
module adder_share_sched #(
    parameter int NREQ = 4,
    parameter int PTRW = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    input  logic [NREQ-1:0]      req_sub,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [31:0]          rsp_z,
    output logic                 rsp_cout,
    output logic                 rsp_ovf,
    output logic                 busy,
    output logic [31:0]          add_a,
    output logic [31:0]          add_b,
    output logic                 add_cin,
    input  logic [31:0]          add_z,
    input  logic                 add_cout
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q, state_d;
    logic [PTRW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTRW-1:0]   grant_q, grant_d;
    logic [31:0]       op_a_q, op_a_d;
    logic [31:0]       op_b_q, op_b_d;
    logic              op_cin_q, op_cin_d;
    logic [31:0]       rsp_z_q, rsp_z_d;
    logic              rsp_cout_q, rsp_cout_d;
    logic              rsp_ovf_q, rsp_ovf_d;

    logic              sel_found;
    logic [PTRW-1:0]   sel_idx;
    logic [31:0]       sel_a;
    logic [31:0]       sel_b;
    logic              sel_sub;
    logic              grant_rsp_ready;
    int                arb_idx;

    // Circular search starting at rr_ptr; the first valid requester wins.
    // The selected requester's operands are muxed out with a constant-index
    // loop so no variable part-select is needed.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_sub   = 1'b0;
        arb_idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            arb_idx = int'(rr_ptr_q) + i;
            if (arb_idx >= NREQ) begin
                arb_idx = arb_idx - NREQ;
            end
            if (!sel_found && req_valid[arb_idx]) begin
                sel_found = 1'b1;
                sel_idx   = PTRW'(arb_idx);
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (sel_idx == PTRW'(k)) begin
                sel_a   = req_a[32*k +: 32];
                sel_b   = req_b[32*k +: 32];
                sel_sub = req_sub[k];
            end
        end
    end

    // Response valid goes only to the granted requester, and only its
    // rsp_ready can complete the response.
    always_comb begin
        rsp_valid       = '0;
        grant_rsp_ready = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_q == PTRW'(k)) begin
                grant_rsp_ready = rsp_ready[k];
                rsp_valid[k]    = (state_q == RESP);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_cin_d   = op_cin_q;
        rsp_z_d    = rsp_z_q;
        rsp_cout_d = rsp_cout_q;
        rsp_ovf_d  = rsp_ovf_q;
        req_ready  = '0;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    for (int k = 0; k < NREQ; k++) begin
                        req_ready[k] = (sel_idx == PTRW'(k));
                    end
                    grant_d  = sel_idx;
                    op_a_d   = sel_a;
                    // Subtract is A + ~B + 1, the +1 entering as carry-in.
                    op_b_d   = sel_sub ? ~sel_b : sel_b;
                    op_cin_d = sel_sub;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_z_d    = add_z;
                rsp_cout_d = add_cout;
                // Overflow uses the already-inverted B, so one rule covers add and sub.
                rsp_ovf_d  = (op_a_q[31] == op_b_q[31]) && (add_z[31] != op_a_q[31]);
                state_d    = RESP;
            end
            RESP: begin
                if (grant_rsp_ready) begin
                    // Pointer moves past the requester just served, only on completion.
                    rr_ptr_d = (grant_q == PTRW'(NREQ-1)) ? '0 : grant_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_cin_q   <= 1'b0;
            rsp_z_q    <= '0;
            rsp_cout_q <= 1'b0;
            rsp_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_cin_q   <= op_cin_d;
            rsp_z_q    <= rsp_z_d;
            rsp_cout_q <= rsp_cout_d;
            rsp_ovf_q  <= rsp_ovf_d;
        end
    end

    assign add_a    = op_a_q;
    assign add_b    = op_b_q;
    assign add_cin  = op_cin_q;
    assign rsp_z    = rsp_z_q;
    assign rsp_cout = rsp_cout_q;
    assign rsp_ovf  = rsp_ovf_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_adder_share_sched.sv
// tb_adder_share_sched
// Directed bench for adder_share_sched with four requesters. The bench also
// plays the role of the shared external adder. Stimulus and checks happen
// just after the falling clock edge, away from the active rising edge.
module tb_adder_share_sched;

    localparam int NREQ = 4;
    localparam int PTRW = 2;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      req_sub;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [31:0]          rsp_z;
    logic                 rsp_cout;
    logic                 rsp_ovf;
    logic                 busy;
    logic [31:0]          add_a;
    logic [31:0]          add_b;
    logic                 add_cin;
    logic [31:0]          add_z;
    logic                 add_cout;

    int n_checks;
    int n_fail;

    adder_share_sched #(.NREQ(NREQ), .PTRW(PTRW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_z     (add_z),
        .add_cout  (add_cout)
    );

    // The external ripple-carry adder the block is sharing.
    always_comb begin
        {add_cout, add_z} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Requester obligations: hold valid and operands steady until accepted.
    logic [NREQ-1:0]    prev_valid;
    logic [NREQ-1:0]    prev_ready;
    logic [32*NREQ-1:0] prev_a;
    logic [32*NREQ-1:0] prev_b;
    logic [NREQ-1:0]    prev_sub;
    logic               prev_chk = 1'b0;

    always @(posedge clk) begin
        if (!reset && prev_chk) begin
            for (int k = 0; k < NREQ; k++) begin
                if (prev_valid[k] && !prev_ready[k]) begin
                    assert (req_valid[k])
                        else $error("[TB] requester %0d dropped req_valid before req_ready", k);
                    assert (req_a[32*k +: 32] == prev_a[32*k +: 32] &&
                            req_b[32*k +: 32] == prev_b[32*k +: 32] &&
                            req_sub[k] == prev_sub[k])
                        else $error("[TB] requester %0d changed operands while waiting", k);
                end
            end
        end
        prev_valid <= req_valid;
        prev_ready <= req_ready;
        prev_a     <= req_a;
        prev_b     <= req_b;
        prev_sub   <= req_sub;
        prev_chk   <= !reset;
    end

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b, input logic sub);
        req_a[32*k +: 32] = a;
        req_b[32*k +: 32] = b;
        req_sub[k]        = sub;
        req_valid[k]      = 1'b1;
    endtask

    task automatic drop_req(input int k);
        req_valid[k] = 1'b0;
    endtask

    // One complete transaction on requester k; caller is just after a falling
    // edge with the block in IDLE, and returns in the same position.
    task automatic do_op(input string tag, input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [31:0] ez, input logic ec, input logic eo);
        logic [NREQ-1:0] onehot;
        logic [31:0]     eb;
        onehot    = '0;
        onehot[k] = 1'b1;
        eb        = sub ? ~b : b;
        set_req(k, a, b, sub);
        #1;
        n_checks++;
        if (req_ready !== onehot) begin n_fail++; $display("[TB] FAIL %s accept req_ready: got %b expected %b", tag, req_ready, onehot); end
        @(negedge clk);
        drop_req(k);
        #1;
        n_checks++;
        if (busy !== 1'b1 || req_ready !== 4'b0000 || rsp_valid !== 4'b0000) begin
            n_fail++; $display("[TB] FAIL %s exec status: got busy=%b req_ready=%b rsp_valid=%b expected 1 0000 0000", tag, busy, req_ready, rsp_valid);
        end
        n_checks++;
        if (add_a !== a || add_b !== eb || add_cin !== sub) begin
            n_fail++; $display("[TB] FAIL %s adder operands: got %h %h %b expected %h %h %b", tag, add_a, add_b, add_cin, a, eb, sub);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== onehot) begin n_fail++; $display("[TB] FAIL %s rsp_valid: got %b expected %b", tag, rsp_valid, onehot); end
        n_checks++;
        if (rsp_z !== ez || rsp_cout !== ec || rsp_ovf !== eo) begin
            n_fail++; $display("[TB] FAIL %s result: got z=%h cout=%b ovf=%b expected z=%h cout=%b ovf=%b", tag, rsp_z, rsp_cout, rsp_ovf, ez, ec, eo);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL %s back to idle: got rsp_valid=%b busy=%b expected 0000 0", tag, rsp_valid, busy);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        rsp_ready = '1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000 || busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset handshake: got req_ready=%b rsp_valid=%b busy=%b expected 0000 0000 0", req_ready, rsp_valid, busy);
        end
        n_checks++;
        if (add_a !== 32'h0 || add_b !== 32'h0 || add_cin !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset adder operands: got %h %h %b expected 0 0 0", add_a, add_b, add_cin);
        end
        n_checks++;
        if (rsp_z !== 32'h0 || rsp_cout !== 1'b0 || rsp_ovf !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset result: got %h %b %b expected 0 0 0", rsp_z, rsp_cout, rsp_ovf);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_add();
        do_op("add_5_3", 0, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
    endtask

    task automatic test_sub();
        do_op("sub_3_5", 2, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_op("sub_5_3", 2, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        do_op("ovf_pos", 1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        do_op("wrap",    3, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    endtask

    // Previous transactions leave rr_ptr at 0 (last one was requester 3).
    task automatic test_round_robin();
        logic [31:0]     ta [NREQ];
        logic [31:0]     tb [NREQ];
        logic [31:0]     tz [NREQ];
        logic [NREQ-1:0] ts;
        logic [NREQ-1:0] onehot;
        int              g;
        ta = '{32'h10, 32'h20, 32'h30, 32'h40};
        tb = '{32'h01, 32'h02, 32'h03, 32'h04};
        tz = '{32'h11, 32'h22, 32'h33, 32'h3C};
        ts = 4'b1000;
        for (int k = 0; k < NREQ; k++) begin
            set_req(k, ta[k], tb[k], ts[k]);
        end
        #1;
        for (int i = 0; i < 5; i++) begin
            g         = i % NREQ;
            onehot    = '0;
            onehot[g] = 1'b1;
            n_checks++;
            if (req_ready !== onehot) begin n_fail++; $display("[TB] FAIL rr grant %0d: got %b expected %b", i, req_ready, onehot); end
            @(negedge clk);
            #1;
            n_checks++;
            if (req_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL rr exec ready %0d: got %b expected 0000", i, req_ready); end
            @(negedge clk);
            #1;
            n_checks++;
            if (rsp_valid !== onehot || rsp_z !== tz[g]) begin
                n_fail++; $display("[TB] FAIL rr response %0d: got rsp_valid=%b z=%h expected %b %h", i, rsp_valid, rsp_z, onehot, tz[g]);
            end
            @(negedge clk);
            #1;
        end
        reset     = 1'b1;
        req_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_backpressure();
        rsp_ready = 4'b1101;
        set_req(1, 32'h1234_5678, 32'h1111_1111, 1'b0);
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin n_fail++; $display("[TB] FAIL bp accept: got %b expected 0010", req_ready); end
        @(negedge clk);
        drop_req(1);
        set_req(0, 32'h0000_000A, 32'h0000_000B, 1'b0);
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL bp exec ready: got %b expected 0000", req_ready); end
        @(negedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 4'b0010 || rsp_z !== 32'h2345_6789) begin
            n_fail++; $display("[TB] FAIL bp response: got %b %h expected 0010 23456789", rsp_valid, rsp_z);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rsp_ready[3] = ~rsp_ready[3];
            #1;
            n_checks++;
            if (rsp_valid !== 4'b0010 || rsp_z !== 32'h2345_6789 || req_ready !== 4'b0000 || busy !== 1'b1) begin
                n_fail++; $display("[TB] FAIL bp hold %0d: got rsp_valid=%b z=%h req_ready=%b busy=%b expected 0010 23456789 0000 1", i, rsp_valid, rsp_z, req_ready, busy);
            end
        end
        @(negedge clk);
        rsp_ready = 4'b1111;
        #1;
        n_checks++;
        if (rsp_valid !== 4'b0010) begin n_fail++; $display("[TB] FAIL bp still held: got %b expected 0010", rsp_valid); end
        @(negedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 4'b0000 || req_ready !== 4'b0001) begin
            n_fail++; $display("[TB] FAIL bp release: got rsp_valid=%b req_ready=%b expected 0000 0001", rsp_valid, req_ready);
        end
        @(negedge clk);
        drop_req(0);
        @(negedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 4'b0001 || rsp_z !== 32'h0000_0015) begin
            n_fail++; $display("[TB] FAIL bp waiting requester: got %b %h expected 0001 00000015", rsp_valid, rsp_z);
        end
        @(negedge clk);
        #1;
    endtask

    // rr_ptr is 1 on entry, so a pointer that survives reset picks requester 3.
    task automatic test_reset_mid();
        set_req(2, 32'h0000_0100, 32'h0000_0001, 1'b0);
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin n_fail++; $display("[TB] FAIL rst accept: got %b expected 0100", req_ready); end
        @(negedge clk);
        drop_req(2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin
            n_fail++; $display("[TB] FAIL rst in exec: got busy=%b rsp_valid=%b expected 0 0000", busy, rsp_valid);
        end
        set_req(0, 32'h0000_0001, 32'h0000_0001, 1'b0);
        set_req(3, 32'h0000_0050, 32'h0000_0020, 1'b1);
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL rst exec pointer: got %b expected 0001", req_ready); end
        @(negedge clk);
        drop_req(0);
        @(negedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 4'b0001 || rsp_z !== 32'h0000_0002) begin
            n_fail++; $display("[TB] FAIL rst post op: got %b %h expected 0001 00000002", rsp_valid, rsp_z);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin n_fail++; $display("[TB] FAIL rst next grant: got %b expected 1000", req_ready); end
        @(negedge clk);
        drop_req(3);
        @(negedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 4'b1000 || rsp_z !== 32'h0000_0030 || rsp_cout !== 1'b1) begin
            n_fail++; $display("[TB] FAIL rst resp result: got %b %h %b expected 1000 00000030 1", rsp_valid, rsp_z, rsp_cout);
        end
        rsp_ready = 4'b0000;
        reset     = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        rsp_ready = 4'b1111;
        #1;
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 4'b0000 || rsp_z !== 32'h0 || rsp_cout !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rst in resp: got busy=%b rsp_valid=%b z=%h cout=%b expected 0 0000 0 0", busy, rsp_valid, rsp_z, rsp_cout);
        end
        set_req(0, 32'h0000_0007, 32'h0000_0002, 1'b1);
        set_req(3, 32'h0000_0050, 32'h0000_0020, 1'b1);
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL rst resp pointer: got %b expected 0001", req_ready); end
        reset     = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_share_sched.md
Name: adder_share_sched

Overview:
- Round-robin scheduler that shares one external 32-bit ripple-carry adder instance among NREQ requesters.
- Each requester issues an add or subtract through a valid/ready handshake.
- The block latches the operands, drives the shared adder, captures the sum and flags, and returns them through a per-requester response handshake.
- It sits between ALU-side clients (for example PC increment, branch target, address calculation) and the single adder datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PTRW, 2, width of grant/pointer index; must satisfy 2**PTRW >= NREQ.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester request accept; one-hot or zero.
- req_a  in  32*NREQ  flattened operand A; requester k uses bits [32k+31:32k].
- req_b  in  32*NREQ  flattened operand B; same layout as req_a.
- req_sub  in  NREQ  1 = compute A-B, 0 = compute A+B.
- rsp_valid  out  NREQ  per-requester response valid; one-hot or zero.
- rsp_ready  in  NREQ  per-requester response accept.
- rsp_z  out  32  result; shared bus, qualified by rsp_valid.
- rsp_cout  out  1  adder carry-out (for subtract, 1 = no borrow).
- rsp_ovf  out  1  signed overflow.
- busy  out  1  high in any state other than IDLE.
- add_a  out  32  to shared adder input a.
- add_b  out  32  to shared adder input b (already inverted for subtract).
- add_cin  out  1  to shared adder carry-in.
- add_z  in  32  from shared adder sum.
- add_cout  in  1  from shared adder carry-out.

Behaviour:
- FSM has three states: IDLE, EXEC, RESP.
- Reset values (reset at rising clk edge):
  - state = IDLE, rr_ptr = 0, grant = 0.
  - Operand registers = 0, so add_a, add_b and add_cin are 0.
  - rsp_z = 0, rsp_cout = 0, rsp_ovf = 0, rsp_valid = 0, req_ready = 0, busy = 0.
- Reset mid-operation: any in-flight request or pending response is discarded without a response; the FSM returns to IDLE.
- IDLE:
  - Arbitration is combinational. Search from index rr_ptr upward, modulo NREQ, and select the first k with req_valid[k]=1.
  - If a requester is found, req_ready[k]=1 in that same cycle and the handshake completes.
  - On that edge: grant <= k; op_a <= A_k; op_b <= (req_sub[k] ? ~B_k : B_k); op_cin <= req_sub[k]. Next state is EXEC.
  - If no req_valid is set, req_ready = 0 and the FSM stays in IDLE.
  - req_ready is asserted only in IDLE.
- EXEC (exactly one cycle):
  - add_a, add_b and add_cin are driven from the operand registers in every state; the adder is purely combinational.
  - On the edge: rsp_z <= add_z; rsp_cout <= add_cout.
  - rsp_ovf <= (op_a[31] == op_b[31]) && (add_z[31] != op_a[31]).
  - Next state is RESP.
- RESP:
  - rsp_valid[grant] = 1; all other rsp_valid bits are 0.
  - rsp_z, rsp_cout and rsp_ovf are held stable until the response handshake.
  - When rsp_ready[grant]=1: rr_ptr <= (grant == NREQ-1) ? 0 : grant+1, and next state is IDLE.
  - rsp_ready from non-granted requesters is ignored.
- Latency and throughput:
  - Request accept to rsp_valid high is 2 cycles.
  - Minimum issue interval is 3 cycles (IDLE, EXEC, RESP).
  - A request from the same requester may be accepted on the cycle after its response handshake.
- Fairness:
  - The pointer advances only on response completion.
  - With all requesters continuously valid, the grant order is 0,1,..,NREQ-1,0,...
  - No requester waits for more than NREQ-1 other operations.
- Requester obligations (checked by assertion in the bench, not by the block):
  - req_a, req_b and req_sub are stable while req_valid is high.
  - A requester does not drop req_valid before it receives req_ready.
- Arithmetic:
  - All arithmetic is modulo 2^32.
  - Subtract uses two's complement (~B + 1 via cin).
  - For subtract, cout=1 iff A >= B unsigned.
- Simultaneous events: a new req_valid that rises during EXEC or RESP waits for IDLE; it is not queued separately.

Test Plan:
- Reset, then a single add on requester 0: A=0x00000005, B=0x00000003, sub=0 → req_ready[0] in the accept cycle; rsp_valid[0] 2 cycles later; rsp_z=0x00000008, cout=0, ovf=0.
- Subtract on requester 2: A=3, B=5 → rsp_z=0xFFFFFFFE, cout=0, ovf=0. Then A=5, B=3 → rsp_z=2, cout=1.
- Overflow and wrap:
  - Add 0x7FFFFFFF+1 → rsp_z=0x80000000, ovf=1, cout=0.
  - Add 0xFFFFFFFF+1 → rsp_z=0, cout=1, ovf=0.
- Round-robin: all 4 requesters held valid with distinct operands → grants in order 0,1,2,3,0 with one response per 3 cycles when rsp_ready is tied high; every response carries the correct rsp_z.
- Backpressure: hold rsp_ready[1]=0 for 5 cycles → rsp_valid[1] and rsp_z stay stable, req_ready stays 0 for all requesters, and the FSM stays in RESP. Pulsing rsp_ready[3] has no effect.
- Reset mid-operation: assert reset in EXEC, then again in a separate run in RESP → the next cycle has state IDLE, all rsp_valid=0 and rr_ptr=0; a subsequent request from requester 0 is granted first.
